operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter TAG_W, default 8, width of the instruction tag carried alongside operands.
REQ-002 SHALL have CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have issue_valid  input  1  upstream request valid.
REQ-005 SHALL have issue_ready  output  1  request accepted when issue_valid && issue_ready.
REQ-006 SHALL have issue_rs1, issue_rs2  input  5 each  source register indices.
REQ-007 SHALL have issue_tag  input  TAG_W  opaque tag, passed through unchanged.
REQ-008 SHALL have rf_ra, rf_rb  output  5 each  register-file read addresses (1-cycle registered read).
REQ-009 SHALL have rf_da, rf_db  input  32 each  register-file read data for the addresses presented the previous cycle.
REQ-010 SHALL have wb_valid, wb_rd, wb_data  input  1/5/32  writeback request.
REQ-011 SHALL have rf_we, rf_rw, rf_dw  output  1/5/32  register-file write port.
REQ-012 SHALL have flush  input  1  discard all in-flight requests.
REQ-013 SHALL have op_valid, op_ready  output/input  1 each  downstream handshake.
REQ-014 SHALL have op_a, op_b  output  32 each, and op_tag  output  TAG_W  resolved operands and tag.

Function
REQ-015 SHALL drive rf_we = wb_valid && (wb_rd != 0), rf_rw = wb_rd, rf_dw = wb_data combinationally.
REQ-016 SHALL contain two stages: S1 (RF data returning) and OUT (operands held for downstream), each with a valid bit.
REQ-017 SHALL define s1_adv = s1_valid && (!out_valid || op_ready); issue_ready = !s1_valid || s1_adv.
REQ-018 SHALL drive rf_ra/rf_rb from issue_rs1/issue_rs2 when issue_ready is high, otherwise from the S1-held indices (re-read while stalled).
REQ-019 SHALL, on accept, load S1 with rs1, rs2, tag and set s1_valid; otherwise clear s1_valid when s1_adv.
REQ-020 SHALL, every cycle, per operand, record a forward flag and data when rf_we is high and rf_rw equals the address driven on rf_ra/rf_rb that cycle; clear the flag otherwise.
REQ-021 SHALL resolve each S1 operand as: index 0 -> 0; else same-cycle rf_we match -> wb_data; else forward flag set -> forwarded data; else rf_da/rf_db.
REQ-022 SHALL, on s1_adv, load OUT with the resolved operands and tag and set out_valid; clear out_valid on op_valid && op_ready without s1_adv.
REQ-023 SHALL, while OUT holds without transfer, replace op_a (op_b) with wb_data when rf_we and rf_rw equals the held rs1 (rs2), index 0 excluded.
REQ-024 SHALL give latency 2: accepted at cycle T -> op_valid at T+2 with no stall; throughput 1 request/cycle.
REQ-025 SHALL keep op_a, op_b, op_tag stable while op_valid && !op_ready, except updates per REQ-023.
REQ-026 SHALL, on flush, clear s1_valid and out_valid next edge, ignore a same-cycle issue, force issue_ready=0 that cycle; writeback port unaffected.
REQ-027 SHALL never produce a non-zero operand for index 0, even if wb_rd=0 with wb_valid.

Reset
REQ-028 SHALL, on RST, clear s1_valid, out_valid and forward flags; op_a, op_b, op_tag reset to 0; RST takes priority over flush and issue.
REQ-029 SHALL hold issue_ready=0 during the RST cycle; rf_we follows REQ-015 regardless of RST.
REQ-030 SHALL discard any request in flight when RST asserts mid-operation; no op_valid pulse for it after reset.

Verification
REQ-031 SHALL verify: x5=0x11 in RF, issue rs1=5 rs2=0 tag=0x3A, op_ready=1 -> op_valid at T+2, op_a=0x11, op_b=0, op_tag=0x3A.
REQ-032 SHALL verify: issue rs1=7 at T with wb rd=7 data=0xDEADBEEF at T -> op_a=0xDEADBEEF (not stale RF value).
REQ-033 SHALL verify: op_ready=0 with OUT holding rs2=9, then wb rd=9 data=0x55 -> op_b becomes 0x55; after op_ready=1 one transfer only.
REQ-034 SHALL verify: back-to-back issues tags 1..4, op_ready toggling 1,0,1,1 -> tags emitted in order 1,2,3,4, none lost or duplicated, issue_ready low only when S1 stalled.
REQ-035 SHALL verify: wb_valid=1 rd=0 data=0xFFFFFFFF -> rf_we=0 and a following rs1=0 read yields op_a=0.
REQ-036 SHALL verify: flush, then separately RST, asserted with both stages valid -> op_valid=0 next cycle, issue_ready=1 the cycle after, subsequent issue completes normally.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two source registers from a 1-cycle registered
// register file, resolves them against in-flight writebacks, and presents
// the operands plus an opaque tag to a valid/ready consumer.
// Pipeline: S1 (register-file data returning) -> OUT (held for downstream).
module operand_fetch #(
  parameter int TAG_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [TAG_W-1:0] issue_tag,
  output logic [4:0]       rf_ra,
  output logic [4:0]       rf_rb,
  input  logic [31:0]      rf_da,
  input  logic [31:0]      rf_db,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_data,
  output logic             rf_we,
  output logic [4:0]       rf_rw,
  output logic [31:0]      rf_dw,
  input  logic             flush,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [31:0]      op_a,
  output logic [31:0]      op_b,
  output logic [TAG_W-1:0] op_tag
);

  logic             s1_valid_reg;
  logic             out_valid_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [TAG_W-1:0] op_tag_reg;
  logic             s1_adv;
  logic             accept;

  // Per-operand views: index 0 is operand A (rs1), index 1 is operand B (rs2).
  logic [1:0][4:0]  issue_idx;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rf_rdata;
  logic [1:0][31:0] op_data;

  // Writeback is forwarded straight to the register file; x0 is never written.
  assign rf_we = wb_valid && (wb_rd != 5'd0);
  assign rf_rw = wb_rd;
  assign rf_dw = wb_data;

  assign issue_idx = {issue_rs2, issue_rs1};
  assign rf_rdata  = {rf_db, rf_da};
  assign rf_ra     = rd_addr[0];
  assign rf_rb     = rd_addr[1];
  assign op_a      = op_data[0];
  assign op_b      = op_data[1];
  assign op_tag    = op_tag_reg;
  assign op_valid  = out_valid_reg;

  // Handshake: S1 drains into OUT when OUT is empty or being consumed;
  // a new request may enter whenever S1 is empty or draining.
  always_comb begin
    s1_adv      = s1_valid_reg && (!out_valid_reg || op_ready);
    issue_ready = !RST && !flush && (!s1_valid_reg || s1_adv);
    accept      = issue_valid && issue_ready;
  end

  // Stage valid bits and the tag that travels alongside the operands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s1_tag_reg    <= '0;
      op_tag_reg    <= '0;
    end else if (flush) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_tag_reg   <= issue_tag;
      end else if (s1_adv) begin
        s1_valid_reg <= 1'b0;
      end
      if (s1_adv) begin
        out_valid_reg <= 1'b1;
        op_tag_reg    <= s1_tag_reg;
      end else if (out_valid_reg && op_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [4:0]  s1_idx_reg;
      logic [4:0]  out_idx_reg;
      logic        fwd_flag_reg;
      logic [31:0] fwd_data_reg;
      logic [31:0] op_data_reg;
      logic [31:0] resolved;
      logic        hold_hit;

      // While S1 is stalled the held index is re-read so the RF data stays fresh.
      assign rd_addr[gi] = issue_ready ? issue_idx[gi] : s1_idx_reg;
      assign op_data[gi] = op_data_reg;

      // The RF returns pre-write data when a write lands on the address being
      // read, so remember that write for use when the data comes back.
      always_ff @(posedge CLK) begin
        if (RST) begin
          fwd_flag_reg <= 1'b0;
          fwd_data_reg <= '0;
        end else begin
          fwd_flag_reg <= rf_we && (rf_rw == rd_addr[gi]);
          fwd_data_reg <= wb_data;
        end
      end

      // S1 register index captured on accept.
      always_ff @(posedge CLK) begin
        if (RST) begin
          s1_idx_reg <= '0;
        end else if (accept) begin
          s1_idx_reg <= issue_idx[gi];
        end
      end

      // Operand resolution priority: x0, same-cycle writeback, remembered write, RF data.
      always_comb begin
        resolved = rf_rdata[gi];
        if (s1_idx_reg == 5'd0) begin
          resolved = '0;
        end else if (rf_we && (rf_rw == s1_idx_reg)) begin
          resolved = wb_data;
        end else if (fwd_flag_reg) begin
          resolved = fwd_data_reg;
        end
      end

      // A writeback to a held operand's register refreshes it while OUT waits.
      assign hold_hit = out_valid_reg && !op_ready && rf_we &&
                        (out_idx_reg != 5'd0) && (rf_rw == out_idx_reg);

      // OUT operand register: load on advance, otherwise track writebacks while held.
      always_ff @(posedge CLK) begin
        if (RST) begin
          op_data_reg <= '0;
          out_idx_reg <= '0;
        end else if (!flush) begin
          if (s1_adv) begin
            op_data_reg <= resolved;
            out_idx_reg <= s1_idx_reg;
          end else if (hold_hit) begin
            op_data_reg <= wb_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: behavioural register file with
// registered read (old data on same-address write), a table of single
// requests, and hand-written multi-cycle sequences for stalls, flush and reset.
module tb_operand_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1, issue_rs2;
  logic [7:0]  issue_tag;
  logic [4:0]  rf_ra, rf_rb;
  logic [31:0] rf_da, rf_db;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_dw;
  logic        flush;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [7:0]  op_tag;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rf_load;
  logic [31:0] rf_mem [32];

  operand_fetch #(.TAG_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_tag(issue_tag),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_da(rf_da), .rf_db(rf_db),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_dw(rf_dw),
    .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_tag(op_tag)
  );

  always #5 CLK = ~CLK;

  // Register file model: x[i] preset to 0xA00000ii, read data registered.
  always @(posedge CLK) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA000_0000 | i;
    end else if (rf_we) begin
      rf_mem[rf_rw] <= rf_dw;
    end
    rf_da <= rf_mem[rf_ra];
    rf_db <= rf_mem[rf_rb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated request with op_ready=1; called and returns at a negedge.
  task automatic do_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic [7:0] tag,
                       input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic ewe, input logic [31:0] ea, input logic [31:0] eb);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_tag = tag;
    wb_valid = wv; wb_rd = wrd; wb_data = wd; op_ready = 1'b1;
    #2;
    check("issue_ready", 32'(issue_ready), 32'd1);
    check("rf_we", 32'(rf_we), 32'(ewe));
    @(negedge CLK);
    issue_valid = 1'b0; wb_valid = 1'b0;
    #2;
    check("op_valid_t1", 32'(op_valid), 32'd0);
    @(negedge CLK);
    #2;
    check("op_valid_t2", 32'(op_valid), 32'd1);
    check("op_a", op_a, ea);
    check("op_b", op_b, eb);
    check("op_tag", 32'(op_tag), 32'(tag));
    $display("txn tag=%h rs1=%0d rs2=%0d op_a=%h op_b=%h", op_tag, rs1, rs2, op_a, op_b);
    @(negedge CLK);
  endtask

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [7:0]  tag;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        ewe;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vecs [8];
  logic rdy_pat [10];
  logic exp_ir  [7];
  logic [7:0] emitted [$];
  int idx;

  initial begin
    vecs[0] = '{5'd1,  5'd2,  8'h01, 1'b1, 5'd5,  32'h0000_0011, 1'b1, 32'hA000_0001, 32'hA000_0002};
    vecs[1] = '{5'd5,  5'd0,  8'h3A, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0000_0011, 32'h0};
    vecs[2] = '{5'd7,  5'd3,  8'h07, 1'b1, 5'd7,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hA000_0003};
    vecs[3] = '{5'd7,  5'd7,  8'h08, 1'b0, 5'd0,  32'h0,         1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[4] = '{5'd0,  5'd4,  8'h10, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'hA000_0004};
    vecs[5] = '{5'd0,  5'd0,  8'hFF, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0};
    vecs[6] = '{5'd31, 5'd30, 8'h55, 1'b1, 5'd30, 32'h1234_5678, 1'b1, 32'hA000_001F, 32'h1234_5678};
    vecs[7] = '{5'd2,  5'd9,  8'hC3, 1'b1, 5'd12, 32'h0000_CAFE, 1'b1, 32'hA000_0002, 32'hA000_0009};
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ir  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    RST = 1'b1; rf_load = 1'b1; flush = 1'b0; issue_valid = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_tag = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; op_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("issue_ready_in_rst", 32'(issue_ready), 32'd0);
    RST = 1'b0; rf_load = 1'b0;
    #2;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_a", op_a, 32'h0);
    check("rst_op_b", op_b, 32'h0);
    check("rst_op_tag", 32'(op_tag), 32'h0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge CLK);

    // Table of isolated requests.
    for (int v = 0; v < 8; v++)
      do_op(vecs[v].rs1, vecs[v].rs2, vecs[v].tag, vecs[v].wv, vecs[v].wrd,
            vecs[v].wd, vecs[v].ewe, vecs[v].ea, vecs[v].eb);

    // Writeback landing while the request sits in S1.
    issue_valid = 1'b1; issue_rs1 = 5'd11; issue_rs2 = 5'd0; issue_tag = 8'h11; op_ready = 1'b1;
    @(negedge CLK);
    issue_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd11; wb_data = 32'hBEEF_0011;
    @(negedge CLK);
    wb_valid = 1'b0;
    #2;
    check("s1_fwd_op_valid", 32'(op_valid), 32'd1);
    check("s1_fwd_op_a", op_a, 32'hBEEF_0011);
    $display("txn tag=%h s1 writeback forward op_a=%h", op_tag, op_a);
    @(negedge CLK);

    // Held OUT operand refreshed by a writeback, then a single transfer.
    issue_valid = 1'b1; issue_rs1 = 5'd3; issue_rs2 = 5'd9; issue_tag = 8'h33; op_ready = 1'b0;
    @(negedge CLK);
    issue_valid = 1'b0;
    @(negedge CLK);
    #2;
    check("hold_op_valid", 32'(op_valid), 32'd1);
    check("hold_op_b_pre", op_b, 32'hA000_0009);
    check("hold_issue_ready", 32'(issue_ready), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0055;
    @(negedge CLK);
    wb_valid = 1'b0;
    #2;
    check("hold_op_valid2", 32'(op_valid), 32'd1);
    check("hold_op_b_upd", op_b, 32'h0000_0055);
    check("hold_op_a", op_a, 32'hA000_0003);
    check("hold_op_tag", 32'(op_tag), 32'h33);
    $display("txn tag=%h held op_b refreshed to %h", op_tag, op_b);
    op_ready = 1'b1;
    @(negedge CLK);
    #2;
    check("hold_single_xfer", 32'(op_valid), 32'd0);
    @(negedge CLK);

    // Back-to-back tags 1..4 with a downstream stall.
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      issue_valid = (idx < 4);
      issue_tag = 8'(idx + 1); issue_rs1 = 5'(idx + 1); issue_rs2 = 5'd0;
      op_ready = rdy_pat[c];
      #2;
      if (c < 7) check($sformatf("b2b_issue_ready_c%0d", c), 32'(issue_ready), 32'(exp_ir[c]));
      if (op_valid && op_ready) begin
        emitted.push_back(op_tag);
        $display("txn b2b cycle=%0d tag=%h op_a=%h", c, op_tag, op_a);
      end
      if (issue_valid && issue_ready) idx++;
      @(negedge CLK);
    end
    issue_valid = 1'b0;
    check("b2b_count", 32'(emitted.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < emitted.size()) check($sformatf("b2b_tag%0d", i), 32'(emitted[i]), 32'(i + 1));

    // Flush with both stages valid; same-cycle issue must be ignored.
    for (int pass = 0; pass < 2; pass++) begin
      op_ready = 1'b0;
      issue_valid = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_tag = 8'hA1;
      @(negedge CLK);
      issue_tag = 8'hA2; issue_rs1 = 5'd3;
      @(negedge CLK);
      issue_tag = 8'hA3;
      if (pass == 0) flush = 1'b1;
      else begin
        RST = 1'b1; wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444_0004;
      end
      #2;
      check($sformatf("kill%0d_full", pass), 32'(op_valid), 32'd1);
      check($sformatf("kill%0d_issue_ready", pass), 32'(issue_ready), 32'd0);
      if (pass == 1) check("rst_rf_we", 32'(rf_we), 32'd1);
      @(negedge CLK);
      flush = 1'b0; RST = 1'b0; wb_valid = 1'b0; issue_valid = 1'b0;
      #2;
      check($sformatf("kill%0d_op_valid", pass), 32'(op_valid), 32'd0);
      check($sformatf("kill%0d_issue_ready_after", pass), 32'(issue_ready), 32'd1);
      if (pass == 1) check("rst_mid_op_a", op_a, 32'h0);
      @(negedge CLK);
      #2;
      check($sformatf("kill%0d_no_ghost", pass), 32'(op_valid), 32'd0);
      @(negedge CLK);
      if (pass == 0) do_op(5'd1, 5'd2, 8'h5A, 1'b0, 5'd0, 32'h0, 1'b0, 32'hA000_0001, 32'hA000_0002);
      else           do_op(5'd4, 5'd1, 8'h5B, 1'b0, 5'd0, 32'h0, 1'b0, 32'h4444_0004, 32'hA000_0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
